// File: rtl/trace_ring_repository.sv
// Circular trace store: de-duplicated capture while unlocked, in-order replay
// through a valid/ack handshake while locked, with explicit retire of issued entries.
module trace_ring_repository #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int TRACE_ENTRIES   = 64,
  parameter int READ_LATENCY    = 1,
  parameter int MAX_OUTSTANDING = 8,
  parameter int DEDUP           = 1,
  parameter int SEQ_WIDTH       = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 lock,
  input  logic                                 cap_valid,
  input  logic [ADDR_WIDTH-1:0]                cap_addr,
  input  logic [DATA_WIDTH-1:0]                cap_instr,
  output logic                                 cap_ready,
  input  logic                                 req,
  input  logic                                 cancel,
  output logic                                 out_valid,
  output logic [ADDR_WIDTH-1:0]                out_addr,
  output logic [DATA_WIDTH-1:0]                out_instr,
  output logic [SEQ_WIDTH-1:0]                 out_seq,
  input  logic                                 out_ack,
  output logic                                 cancelled,
  input  logic                                 retire,
  output logic                                 retire_err,
  output logic [$clog2(TRACE_ENTRIES):0]       level,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
  output logic                                 full,
  output logic                                 empty,
  output logic                                 exhausted,
  output logic [15:0]                          overflow_count
);
  localparam int IDX_W = $clog2(TRACE_ENTRIES);
  localparam int PTR_W = IDX_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   iss_ptr_q, iss_ptr_d;
  logic [PTR_W-1:0]   ret_ptr_q, ret_ptr_d;
  logic [SEQ_WIDTH-1:0] seq_q, seq_d;
  logic [15:0]        ovf_q, ovf_d;
  logic [ENT_W-1:0]   last_q, last_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [ENT_W-1:0]   out_data_q, out_data_d;
  logic               cancelled_q, cancelled_d;
  logic               retire_err_q, retire_err_d;
  logic               exhausted_q, exhausted_d;
  logic [ENT_W-1:0]   rd_data_q, rd_data_d;

  logic [ENT_W-1:0]   mem [TRACE_ENTRIES];

  logic [PTR_W-1:0]   level_w, outst_w;
  logic [ENT_W-1:0]   cap_entry;
  logic               full_w, is_dup, cap_ok, wr_en, can_issue;

  assign level_w   = wr_ptr_q - ret_ptr_q;
  assign outst_w   = iss_ptr_q - ret_ptr_q;
  assign full_w    = (level_w == PTR_W'(TRACE_ENTRIES));
  assign cap_entry = {cap_addr, cap_instr};
  assign is_dup    = (DEDUP != 0) && (cap_entry == last_q);
  assign cap_ok    = !lock && cap_valid && !is_dup;
  assign wr_en     = cap_ok && !full_w;
  assign can_issue = lock && req && (iss_ptr_q != wr_ptr_q) &&
                     (32'(outst_w) < 32'(MAX_OUTSTANDING));

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    iss_ptr_d    = iss_ptr_q;
    ret_ptr_d    = ret_ptr_q;
    seq_d        = seq_q;
    ovf_d        = ovf_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    cancelled_d  = 1'b0;
    retire_err_d = 1'b0;
    rd_data_d    = mem[iss_ptr_q[IDX_W-1:0]];

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      last_d   = cap_entry;
    end
    if (cap_ok && full_w && (ovf_q != '1)) ovf_d = ovf_q + 16'd1;

    case (state_q)
      IDLE: begin
        if (can_issue) begin
          state_d = FETCH;
          cnt_d   = 3'(READ_LATENCY);
        end
      end
      FETCH, PRESENT: begin
        // Unlock aborts silently; cancel aborts with a pulse and beats a same-cycle ack.
        if (!lock) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else if (cancel) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          cancelled_d = 1'b1;
        end else if (state_q == FETCH) begin
          if (cnt_q == 3'd0) begin
            out_data_d  = rd_data_q;
            out_valid_d = 1'b1;
            state_d     = PRESENT;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end else if (out_ack) begin
          out_valid_d = 1'b0;
          iss_ptr_d   = iss_ptr_q + PTR_W'(1);
          seq_d       = seq_q + SEQ_WIDTH'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (retire) begin
      if (outst_w != '0) ret_ptr_d = ret_ptr_q + PTR_W'(1);
      else               retire_err_d = 1'b1;
    end

    exhausted_d = lock && (iss_ptr_d == wr_ptr_d);
  end

  // Storage holds no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[IDX_W-1:0]] <= cap_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      iss_ptr_q    <= '0;
      ret_ptr_q    <= '0;
      seq_q        <= '0;
      ovf_q        <= '0;
      last_q       <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      cancelled_q  <= 1'b0;
      retire_err_q <= 1'b0;
      exhausted_q  <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      iss_ptr_q    <= iss_ptr_d;
      ret_ptr_q    <= ret_ptr_d;
      seq_q        <= seq_d;
      ovf_q        <= ovf_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      cancelled_q  <= cancelled_d;
      retire_err_q <= retire_err_d;
      exhausted_q  <= exhausted_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign cap_ready      = !lock && !full_w;
  assign out_valid      = out_valid_q;
  assign out_addr       = out_data_q[ENT_W-1:DATA_WIDTH];
  assign out_instr      = out_data_q[DATA_WIDTH-1:0];
  assign out_seq        = seq_q;
  assign cancelled      = cancelled_q;
  assign retire_err     = retire_err_q;
  assign level          = level_w;
  assign outstanding    = OUT_W'(outst_w);
  assign full           = full_w;
  assign empty          = (level_w == '0);
  assign exhausted      = exhausted_q;
  assign overflow_count = ovf_q;
endmodule

// File: tb/tb_trace_ring_repository.sv
// Bench for trace_ring_repository: table vectors, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_trace_ring_repository;
  localparam int TE = 4;
  localparam int MO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0, lock = 1'b0, cap_valid = 1'b0, req = 1'b0;
  logic cancel = 1'b0, out_ack = 1'b0, retire = 1'b0;
  logic [15:0] cap_addr = '0;
  logic [31:0] cap_instr = '0;

  logic cap_ready, out_valid, cancelled, retire_err, full, empty, exhausted;
  logic [15:0] out_addr, out_seq, overflow_count;
  logic [31:0] out_instr;
  logic [2:0] level;
  logic [1:0] outstanding;

  logic b_cap_ready, b_out_valid, b_cancelled, b_retire_err, b_full, b_empty, b_exhausted;
  logic [15:0] b_out_addr, b_out_seq, b_overflow_count;
  logic [31:0] b_out_instr;
  logic [2:0] b_level;
  logic [1:0] b_outstanding;

  trace_ring_repository #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TRACE_ENTRIES(TE),
    .READ_LATENCY(1), .MAX_OUTSTANDING(MO), .DEDUP(1), .SEQ_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .lock(lock), .cap_valid(cap_valid), .cap_addr(cap_addr),
    .cap_instr(cap_instr), .cap_ready(cap_ready), .req(req), .cancel(cancel),
    .out_valid(out_valid), .out_addr(out_addr), .out_instr(out_instr), .out_seq(out_seq),
    .out_ack(out_ack), .cancelled(cancelled), .retire(retire), .retire_err(retire_err),
    .level(level), .outstanding(outstanding), .full(full), .empty(empty),
    .exhausted(exhausted), .overflow_count(overflow_count));

  trace_ring_repository #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .TRACE_ENTRIES(TE),
    .READ_LATENCY(4), .MAX_OUTSTANDING(MO), .DEDUP(1), .SEQ_WIDTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .lock(lock), .cap_valid(cap_valid), .cap_addr(cap_addr),
    .cap_instr(cap_instr), .cap_ready(b_cap_ready), .req(req), .cancel(cancel),
    .out_valid(b_out_valid), .out_addr(b_out_addr), .out_instr(b_out_instr),
    .out_seq(b_out_seq), .out_ack(out_ack), .cancelled(b_cancelled), .retire(retire),
    .retire_err(b_retire_err), .level(b_level), .outstanding(b_outstanding), .full(b_full),
    .empty(b_empty), .exhausted(b_exhausted), .overflow_count(b_overflow_count));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: absolute (unwrapped) counters and a history queue of accepted entries.
  int m_wr, m_iss, m_ret, m_ov, m_left, m_seq;
  bit m_fetch, m_pres, m_canc, m_err, m_exh;
  logic [47:0] m_hist[$];
  logic [47:0] m_last, m_out;

  task automatic model_reset();
    m_wr = 0; m_iss = 0; m_ret = 0; m_ov = 0; m_left = 0; m_seq = 0;
    m_fetch = 0; m_pres = 0; m_canc = 0; m_err = 0; m_exh = 0;
    m_hist.delete(); m_last = '0; m_out = '0;
  endtask

  task automatic model_step();
    int lvl, outst;
    logic [47:0] ent;
    if (!rst_n) begin
      model_reset();
      return;
    end
    lvl = m_wr - m_ret;
    outst = m_iss - m_ret;
    ent = {cap_addr, cap_instr};
    m_canc = 0;
    m_err = 0;
    if (!lock && cap_valid && ent != m_last) begin
      if (lvl != TE) begin
        m_hist.push_back(ent);
        m_wr++;
        m_last = ent;
      end else if (m_ov < 65535) m_ov++;
    end
    if (m_fetch || m_pres) begin
      if (!lock) begin
        m_fetch = 0; m_pres = 0;
      end else if (cancel) begin
        m_fetch = 0; m_pres = 0; m_canc = 1;
      end else if (m_fetch) begin
        if (m_left == 0) begin
          m_fetch = 0; m_pres = 1; m_out = m_hist[m_iss];
        end else m_left--;
      end else if (out_ack) begin
        m_pres = 0; m_iss++; m_seq = (m_seq + 1) % 65536;
      end
    end else if (lock && req && m_iss != m_wr && outst < MO) begin
      m_fetch = 1; m_left = 1;
    end
    if (retire) begin
      if (outst > 0) m_ret++;
      else m_err = 1;
    end
    m_exh = lock && (m_iss == m_wr);
  endtask

  task automatic model_check();
    chk("level", level, m_wr - m_ret);
    chk("outstanding", outstanding, m_iss - m_ret);
    chk("full", full, (m_wr - m_ret) == TE);
    chk("empty", empty, m_wr == m_ret);
    chk("cap_ready", cap_ready, !lock && ((m_wr - m_ret) != TE));
    chk("out_valid", out_valid, m_pres);
    if (m_pres) begin
      chk("out_addr", out_addr, m_out[47:32]);
      chk("out_instr", out_instr, m_out[31:0]);
      chk("out_seq", out_seq, m_seq);
    end
    chk("cancelled", cancelled, m_canc);
    chk("retire_err", retire_err, m_err);
    chk("exhausted", exhausted, m_exh);
    chk("overflow_count", overflow_count, m_ov);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    rst_n = 0; lock = 0; cap_valid = 0; req = 0; cancel = 0; out_ack = 0; retire = 0;
    cycle();
    cycle();
    rst_n = 1;
  endtask

  function automatic logic [47:0] ent_k(input int k);
    return {16'h0100 + 16'(k), 32'hC0DE0000 + 32'(k)};
  endfunction

  task automatic cap(input logic [47:0] e);
    lock = 0; cap_valid = 1; {cap_addr, cap_instr} = e;
    cycle();
    cap_valid = 0;
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 12 && !out_valid; i++) cycle();
    chk(nm, out_valid, 1'b1);
  endtask

  task automatic replay_one(input logic [47:0] e, input int seq, input bit do_ret);
    lock = 1; req = 1;
    wait_valid("replay_wait");
    req = 0;
    chk("replay_addr", out_addr, e[47:32]);
    chk("replay_instr", out_instr, e[31:0]);
    chk("replay_seq", out_seq, seq);
    out_ack = 1;
    cycle();
    out_ack = 0;
    chk("valid_after_ack", out_valid, 1'b0);
    if (do_ret) begin
      retire = 1;
      cycle();
      retire = 0;
    end
  endtask

  typedef struct {
    logic        lk, cv;
    logic [15:0] a;
    logic [31:0] d;
    logic        rq, ak;
    logic [2:0]  e_lvl;
    logic        e_vld;
    logic [15:0] e_a, e_seq;
    logic        e_exh;
    logic [15:0] e_ov;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int n;
    tbl[0]  = '{1'b0, 1'b1, 16'h1111, 32'hAAAA0001, 1'b0, 1'b0, 3'd1, 1'b0, 16'h0,    16'd0, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 1'b1, 16'h1111, 32'hAAAA0001, 1'b0, 1'b0, 3'd1, 1'b0, 16'h0,    16'd0, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 1'b1, 16'h2222, 32'hBBBB0002, 1'b0, 1'b0, 3'd2, 1'b0, 16'h0,    16'd0, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 1'b0, 16'h0,    32'h0,        1'b1, 1'b0, 3'd2, 1'b0, 16'h0,    16'd0, 1'b0, 16'd0};
    tbl[4]  = '{1'b1, 1'b0, 16'h0,    32'h0,        1'b0, 1'b0, 3'd2, 1'b0, 16'h0,    16'd0, 1'b0, 16'd0};
    tbl[5]  = '{1'b1, 1'b0, 16'h0,    32'h0,        1'b0, 1'b0, 3'd2, 1'b1, 16'h1111, 16'd0, 1'b0, 16'd0};
    tbl[6]  = '{1'b1, 1'b0, 16'h0,    32'h0,        1'b0, 1'b1, 3'd2, 1'b0, 16'h0,    16'd0, 1'b0, 16'd0};
    tbl[7]  = '{1'b1, 1'b0, 16'h0,    32'h0,        1'b1, 1'b0, 3'd2, 1'b0, 16'h0,    16'd0, 1'b0, 16'd0};
    tbl[8]  = '{1'b1, 1'b0, 16'h0,    32'h0,        1'b0, 1'b0, 3'd2, 1'b0, 16'h0,    16'd0, 1'b0, 16'd0};
    tbl[9]  = '{1'b1, 1'b0, 16'h0,    32'h0,        1'b0, 1'b0, 3'd2, 1'b1, 16'h2222, 16'd1, 1'b0, 16'd0};
    tbl[10] = '{1'b1, 1'b0, 16'h0,    32'h0,        1'b0, 1'b1, 3'd2, 1'b0, 16'h0,    16'd0, 1'b1, 16'd0};

    model_reset();
    do_reset();
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_cap_ready", cap_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);

    // Dedup capture then in-order replay.
    foreach (tbl[i]) begin
      lock = tbl[i].lk; cap_valid = tbl[i].cv; cap_addr = tbl[i].a; cap_instr = tbl[i].d;
      req = tbl[i].rq; out_ack = tbl[i].ak;
      cycle();
      chk($sformatf("tbl%0d_level", i), level, tbl[i].e_lvl);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_vld);
      if (tbl[i].e_vld) begin
        chk($sformatf("tbl%0d_addr", i), out_addr, tbl[i].e_a);
        chk($sformatf("tbl%0d_seq", i), out_seq, tbl[i].e_seq);
      end
      chk($sformatf("tbl%0d_exh", i), exhausted, tbl[i].e_exh);
      chk($sformatf("tbl%0d_ov", i), overflow_count, tbl[i].e_ov);
    end
    cap_valid = 0; req = 0; out_ack = 0;

    // Fill, overflow, retire, wrap.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      cap(ent_k(k));
      if (k == 4) begin
        chk("fill_full", full, 1'b1);
        chk("fill_cap_ready", cap_ready, 1'b0);
      end
    end
    chk("fill_overflow", overflow_count, 16'd2);
    replay_one(ent_k(1), 0, 1);
    replay_one(ent_k(2), 1, 1);
    chk("wrap_level2", level, 3'd2);
    cap(ent_k(7));
    cap(ent_k(8));
    chk("wrap_level4", level, 3'd4);
    replay_one(ent_k(3), 2, 1);
    replay_one(ent_k(4), 3, 1);
    replay_one(ent_k(7), 4, 1);
    replay_one(ent_k(8), 5, 1);
    chk("wrap_exhausted", exhausted, 1'b1);
    chk("wrap_empty", empty, 1'b1);

    // Outstanding limit holds off req until a retire.
    do_reset();
    for (int k = 1; k <= 4; k++) cap(ent_k(k));
    replay_one(ent_k(1), 0, 0);
    replay_one(ent_k(2), 1, 0);
    chk("limit_outstanding", outstanding, 2'd2);
    lock = 1; req = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("limit_held", out_valid, 1'b0);
    end
    retire = 1;
    cycle();
    retire = 0;
    chk("limit_after_retire", outstanding, 2'd1);
    wait_valid("limit_wait");
    req = 0;
    chk("limit_addr", out_addr, ent_k(3) >> 32);
    chk("limit_seq", out_seq, 16'd2);
    out_ack = 1;
    cycle();
    out_ack = 0;

    // Cancel in FETCH, then cancel beating a same-cycle ack.
    do_reset();
    cap(ent_k(1));
    cap(ent_k(2));
    lock = 1; req = 1;
    cycle();
    req = 0; cancel = 1;
    cycle();
    cancel = 0;
    chk("cancel_fetch_pulse", cancelled, 1'b1);
    chk("cancel_fetch_valid", out_valid, 1'b0);
    cycle();
    chk("cancel_pulse_end", cancelled, 1'b0);
    req = 1;
    wait_valid("cancel_wait");
    req = 0;
    chk("cancel_refetch_addr", out_addr, ent_k(1) >> 32);
    chk("cancel_refetch_seq", out_seq, 16'd0);
    cancel = 1; out_ack = 1;
    cycle();
    cancel = 0; out_ack = 0;
    chk("cancel_ack_pulse", cancelled, 1'b1);
    chk("cancel_ack_valid", out_valid, 1'b0);
    chk("cancel_ack_outst", outstanding, 2'd0);
    replay_one(ent_k(1), 0, 0);

    // Retire underflow and reset mid-presentation.
    do_reset();
    cap(ent_k(1));
    retire = 1;
    cycle();
    retire = 0;
    chk("underflow_err", retire_err, 1'b1);
    chk("underflow_level", level, 3'd1);
    cycle();
    chk("underflow_err_end", retire_err, 1'b0);
    lock = 1; req = 1;
    wait_valid("rst_mid_wait");
    req = 0; rst_n = 0;
    cycle();
    rst_n = 1;
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_level", level, 3'd0);
    chk("rst_mid_empty", empty, 1'b1);

    // READ_LATENCY=4 timing on the second instance; locked capture ignored.
    do_reset();
    cap(ent_k(1));
    lock = 1; req = 1;
    cycle();
    req = 0;
    n = 1;
    while (!b_out_valid && n < 12) begin
      cycle();
      n++;
    end
    chk("lat4_edges", n - 1, 5);
    chk("lat4_addr", b_out_addr, ent_k(1) >> 32);
    cap_valid = 1; {cap_addr, cap_instr} = ent_k(9);
    cycle();
    cap_valid = 0;
    chk("locked_cap_level", level, 3'd1);
    chk("locked_cap_ov", overflow_count, 16'd0);
    chk("locked_cap_level_b", b_level, 3'd1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) lock = ~lock;
      rst_n     = ($urandom_range(0, 499) != 0);
      cap_valid = ($urandom_range(0, 9) < 7);
      cap_addr  = 16'($urandom_range(0, 3));
      cap_instr = 32'($urandom_range(0, 2));
      req       = ($urandom_range(0, 9) < 6);
      out_ack   = $urandom_range(0, 1) == 1;
      cancel    = ($urandom_range(0, 15) == 0);
      retire    = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
